// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I definitions for the fetch/dispatch front end.
//   op_e    - 6-bit decoded operation, OP_ILLEGAL = 0
//   fmt_e   - instruction encoding format used to pick fields/immediate
//   OPC_*   - major opcodes, F3_*/F7_* - function field constants
//   `DATA_IDX_RANGE / `ADDR_IDX - datapath and address width macros
`define DATA_IDX_RANGE 31:0
`define ADDR_IDX 31

package rv32i_pkg;

    typedef enum logic [5:0] {
        OP_ILLEGAL = 6'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU funct3 groups shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational RV32I decoder.
//   instr - raw 32-bit instruction
//   op    - decoded operation (OP_ILLEGAL for unknown encodings)
//   rd/rs1/rs2 - register indices, zero where the format has no such field
//   imm   - sign-extended immediate for the instruction's format
module instr_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  op,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    op_e        op_d;
    fmt_e       fmt;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // opcode/funct classification
    always_comb begin
        op_d = OP_ILLEGAL;
        fmt  = FMT_R;
        case (opc)
            OPC_LUI:   begin op_d = OP_LUI;   fmt = FMT_U; end
            OPC_AUIPC: begin op_d = OP_AUIPC; fmt = FMT_U; end
            OPC_JAL:   begin op_d = OP_JAL;   fmt = FMT_J; end
            OPC_JALR: begin
                fmt = FMT_I;
                if (f3 == 3'b000) op_d = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'b000:  op_d = OP_BEQ;
                    3'b001:  op_d = OP_BNE;
                    3'b100:  op_d = OP_BLT;
                    3'b101:  op_d = OP_BGE;
                    3'b110:  op_d = OP_BLTU;
                    3'b111:  op_d = OP_BGEU;
                    default: op_d = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    3'b000:  op_d = OP_LB;
                    3'b001:  op_d = OP_LH;
                    3'b010:  op_d = OP_LW;
                    3'b100:  op_d = OP_LBU;
                    3'b101:  op_d = OP_LHU;
                    default: op_d = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'b000:  op_d = OP_SB;
                    3'b001:  op_d = OP_SH;
                    3'b010:  op_d = OP_SW;
                    default: op_d = OP_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (f3)
                    F3_ADD:  op_d = OP_ADDI;
                    F3_SLT:  op_d = OP_SLTI;
                    F3_SLTU: op_d = OP_SLTIU;
                    F3_XOR:  op_d = OP_XORI;
                    F3_OR:   op_d = OP_ORI;
                    F3_AND:  op_d = OP_ANDI;
                    // shifts reuse the upper immediate bits as funct7
                    F3_SLL:  op_d = (f7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
                    F3_SR:   op_d = (f7 == F7_BASE) ? OP_SRLI :
                                    (f7 == F7_ALT)  ? OP_SRAI : OP_ILLEGAL;
                    default: op_d = OP_ILLEGAL;
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  op_d = OP_ADD;
                        F3_SLL:  op_d = OP_SLL;
                        F3_SLT:  op_d = OP_SLT;
                        F3_SLTU: op_d = OP_SLTU;
                        F3_XOR:  op_d = OP_XOR;
                        F3_SR:   op_d = OP_SRL;
                        F3_OR:   op_d = OP_OR;
                        F3_AND:  op_d = OP_AND;
                        default: op_d = OP_ILLEGAL;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        F3_ADD:  op_d = OP_SUB;
                        F3_SR:   op_d = OP_SRA;
                        default: op_d = OP_ILLEGAL;
                    endcase
                end
            end
            default: op_d = OP_ILLEGAL;
        endcase
    end

    // field extraction; everything stays zero for an illegal encoding
    always_comb begin
        op  = op_d;
        rd  = '0;
        rs1 = '0;
        rs2 = '0;
        imm = '0;
        if (op_d != OP_ILLEGAL) begin
            case (fmt)
                FMT_R: begin
                    rd = instr[11:7]; rs1 = instr[19:15]; rs2 = instr[24:20];
                end
                FMT_I: begin
                    rd = instr[11:7]; rs1 = instr[19:15];
                    imm = {{20{instr[31]}}, instr[31:20]};
                end
                FMT_S: begin
                    rs1 = instr[19:15]; rs2 = instr[24:20];
                    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                FMT_B: begin
                    rs1 = instr[19:15]; rs2 = instr[24:20];
                    imm = {{19{instr[31]}}, instr[31], instr[7],
                           instr[30:25], instr[11:8], 1'b0};
                end
                FMT_U: begin
                    rd = instr[11:7];
                    imm = {instr[31:12], 12'b0};
                end
                FMT_J: begin
                    rd = instr[11:7];
                    imm = {{11{instr[31]}}, instr[31], instr[19:12],
                           instr[20], instr[30:21], 1'b0};
                end
                default: imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/instr_queue.sv
// instr_queue: circular fetch buffer with a decode/output register feeding
// dispatch.
//   clk, rst (sync, active-low), rdy (global stall), flush (mispredict clear)
//   valid_from_if/instr_from_if/pc_from_if/pred_pc_from_if - fetch push
//   is_full    - back-pressure, occupancy >= DEPTH - FULL_MARGIN
//   disp_ready - dispatch accepts the output register this cycle
//   valid_2disp, op/rd/rs1/rs2/imm/pc/pred_pc_2disp - decoded head entry
module instr_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH_LOG   = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  valid_from_if,
    input  logic [`DATA_IDX_RANGE] instr_from_if,
    input  logic [`ADDR_IDX:0]    pc_from_if,
    input  logic [`ADDR_IDX:0]    pred_pc_from_if,
    output logic                  is_full,
    input  logic                  disp_ready,
    output logic                  valid_2disp,
    output logic [5:0]            op_2disp,
    output logic [4:0]            rd_2disp,
    output logic [4:0]            rs1_2disp,
    output logic [4:0]            rs2_2disp,
    output logic [31:0]           imm_2disp,
    output logic [`ADDR_IDX:0]    pc_2disp,
    output logic [`ADDR_IDX:0]    pred_pc_2disp
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] CNT_MAX  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG + 1)'(DEPTH - FULL_MARGIN);

    logic [`DATA_IDX_RANGE] instr_mem [DEPTH];
    logic [`ADDR_IDX:0]     pc_mem    [DEPTH];
    logic [`ADDR_IDX:0]     pred_mem  [DEPTH];

    logic [DEPTH_LOG-1:0] head, tail;
    logic [DEPTH_LOG:0]   count;
    logic                 push, pop, adv;

    logic [5:0]  dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;

    // state only moves when out of reset, not stalled and not flushing
    assign adv  = rst && rdy && !flush;
    assign push = valid_from_if && (count != CNT_MAX);
    assign pop  = (count != '0) && (!valid_2disp || disp_ready);

    // registered occupancy only, so the fetcher sees no same-cycle path
    assign is_full = (count >= CNT_FULL);

    instr_decode u_dec (
        .instr (instr_mem[head]),
        .op    (dec_op),
        .rd    (dec_rd),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .imm   (dec_imm)
    );

    // storage needs no reset: entries are only visible through count
    always_ff @(posedge clk) begin
        if (adv && push) begin
            instr_mem[tail] <= instr_from_if;
            pc_mem[tail]    <= pc_from_if;
            pred_mem[tail]  <= pred_pc_from_if;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            valid_2disp   <= 1'b0;
            op_2disp      <= OP_ILLEGAL;
            rd_2disp      <= '0;
            rs1_2disp     <= '0;
            rs2_2disp     <= '0;
            imm_2disp     <= '0;
            pc_2disp      <= '0;
            pred_pc_2disp <= '0;
        end else if (rdy) begin
            if (flush) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                valid_2disp <= 1'b0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop) begin
                    head          <= head + 1'b1;
                    valid_2disp   <= 1'b1;
                    op_2disp      <= dec_op;
                    rd_2disp      <= dec_rd;
                    rs1_2disp     <= dec_rs1;
                    rs2_2disp     <= dec_rs2;
                    imm_2disp     <= dec_imm;
                    pc_2disp      <= pc_mem[head];
                    pred_pc_2disp <= pred_mem[head];
                end else if (disp_ready) begin
                    // accepted with nothing behind it
                    valid_2disp <= 1'b0;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, valid_from_if, disp_ready;
    logic [31:0] instr_from_if, pc_from_if, pred_pc_from_if;
    logic        is_full, valid_2disp;
    logic [5:0]  op_2disp;
    logic [4:0]  rd_2disp, rs1_2disp, rs2_2disp;
    logic [31:0] imm_2disp, pc_2disp, pred_pc_2disp;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_queue #(.DEPTH_LOG(4), .FULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .valid_from_if(valid_from_if), .instr_from_if(instr_from_if),
        .pc_from_if(pc_from_if), .pred_pc_from_if(pred_pc_from_if),
        .is_full(is_full), .disp_ready(disp_ready),
        .valid_2disp(valid_2disp), .op_2disp(op_2disp),
        .rd_2disp(rd_2disp), .rs1_2disp(rs1_2disp), .rs2_2disp(rs2_2disp),
        .imm_2disp(imm_2disp), .pc_2disp(pc_2disp), .pred_pc_2disp(pred_pc_2disp)
    );

    typedef struct {
        logic [31:0] instr;
        op_e         op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // inputs are driven 1 time unit after the edge, outputs sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; valid_from_if = 1'b0;
        disp_ready = 1'b0; instr_from_if = '0; pc_from_if = '0; pred_pc_from_if = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic set_push(input logic [31:0] ins, input logic [31:0] pc);
        valid_from_if   = 1'b1;
        instr_from_if   = ins;
        pc_from_if      = pc;
        pred_pc_from_if = pc + 32'd4;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        vecs[0]  = '{32'h00500093, OP_ADDI,    5'd1, 5'd0, 5'd0, 32'h00000005};
        vecs[1]  = '{32'hFE000EE3, OP_BEQ,     5'd0, 5'd0, 5'd0, 32'hFFFFFFFC};
        vecs[2]  = '{32'h123452B7, OP_LUI,     5'd5, 5'd0, 5'd0, 32'h12345000};
        vecs[3]  = '{32'hFFFFF117, OP_AUIPC,   5'd2, 5'd0, 5'd0, 32'hFFFFF000};
        vecs[4]  = '{32'hFF9FF0EF, OP_JAL,     5'd1, 5'd0, 5'd0, 32'hFFFFFFF8};
        vecs[5]  = '{32'h00008067, OP_JALR,    5'd0, 5'd1, 5'd0, 32'h00000000};
        vecs[6]  = '{32'hFFC12183, OP_LW,      5'd3, 5'd2, 5'd0, 32'hFFFFFFFC};
        vecs[7]  = '{32'h00512423, OP_SW,      5'd0, 5'd2, 5'd5, 32'h00000008};
        vecs[8]  = '{32'h402081B3, OP_SUB,     5'd3, 5'd1, 5'd2, 32'h00000000};
        vecs[9]  = '{32'h00321213, OP_SLLI,    5'd4, 5'd4, 5'd0, 32'h00000003};
        vecs[10] = '{32'h0020F863, OP_BGEU,    5'd0, 5'd1, 5'd2, 32'h00000010};
        vecs[11] = '{32'h7FF04383, OP_LBU,     5'd7, 5'd0, 5'd0, 32'h000007FF};
        vecs[12] = '{32'hFFFFFFFF, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000};
        vecs[13] = '{32'h022081B3, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h00000000};

        // ---- reset state ----
        do_reset();
        chk("rst_valid", 32'(valid_2disp), 32'd0);
        chk("rst_full",  32'(is_full), 32'd0);
        chk("rst_op",    32'(op_2disp), 32'd0);
        chk("rst_rd",    32'(rd_2disp), 32'd0);
        chk("rst_imm",   imm_2disp, 32'd0);
        chk("rst_pc",    pc_2disp, 32'd0);
        chk("rst_pred",  pred_pc_2disp, 32'd0);

        // ---- decode table, one instruction at a time, checks t+1/t+2/t+3 ----
        disp_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            set_push(vecs[i].instr, 32'h1000 + 32'(i) * 4);
            step();
            valid_from_if = 1'b0;
            chk("lat_t1_valid", 32'(valid_2disp), 32'd0);
            step();
            chk("vec_valid", 32'(valid_2disp), 32'd1);
            chk("vec_op",    32'(op_2disp), 32'(vecs[i].op));
            chk("vec_rd",    32'(rd_2disp), 32'(vecs[i].rd));
            chk("vec_rs1",   32'(rs1_2disp), 32'(vecs[i].rs1));
            chk("vec_rs2",   32'(rs2_2disp), 32'(vecs[i].rs2));
            chk("vec_imm",   imm_2disp, vecs[i].imm);
            chk("vec_pc",    pc_2disp, 32'h1000 + 32'(i) * 4);
            chk("vec_pred",  pred_pc_2disp, 32'h1004 + 32'(i) * 4);
            step();
            chk("vec_drop", 32'(valid_2disp), 32'd0);
        end

        // ---- fill with dispatch stalled: margin and output hold ----
        do_reset();
        for (int k = 0; k < 16; k++) begin
            set_push(addi(5'd1, 12'(k)), 32'h100 + 32'(k) * 4);
            step();
            if (k == 13) chk("fill_not_full_13", 32'(is_full), 32'd0);
            if (k == 14) chk("fill_full_14", 32'(is_full), 32'd1);
            if (k == 1 || k == 15) begin
                chk("fill_hold_valid", 32'(valid_2disp), 32'd1);
                chk("fill_hold_pc", pc_2disp, 32'h100);
            end
        end
        valid_from_if = 1'b0;
        chk("fill_full_15", 32'(is_full), 32'd1);
        disp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", 32'(valid_2disp), 32'd1);
            chk("drain_pc", pc_2disp, 32'h100 + 32'(k) * 4);
            chk("drain_imm", imm_2disp, 32'(k));
            step();
        end
        chk("drain_end_valid", 32'(valid_2disp), 32'd0);
        chk("drain_end_full", 32'(is_full), 32'd0);

        // ---- sustained throughput across pointer wrap ----
        begin
            int got = 0, first = -1, last = -1;
            logic full_seen = 1'b0;
            do_reset();
            disp_ready = 1'b1;
            for (int c = 0; c < 50; c++) begin
                if (c < 40) set_push(addi(5'd2, 12'(c)), 32'h2000 + 32'(c) * 4);
                else        valid_from_if = 1'b0;
                step();
                if (is_full) full_seen = 1'b1;
                if (valid_2disp) begin
                    chk("thru_pc", pc_2disp, 32'h2000 + 32'(got) * 4);
                    chk("thru_imm", imm_2disp, 32'(got));
                    if (first < 0) first = c;
                    last = c;
                    got++;
                end
            end
            chk("thru_count", 32'(got), 32'd40);
            chk("thru_no_gap", 32'(last - first), 32'd39);
            chk("thru_never_full", 32'(full_seen), 32'd0);
        end

        // ---- flush with concurrent push ----
        begin
            logic seen = 1'b0;
            do_reset();
            for (int k = 0; k < 6; k++) begin
                set_push(addi(5'd3, 12'(k)), 32'h3000 + 32'(k) * 4);
                step();
            end
            chk("pre_flush_valid", 32'(valid_2disp), 32'd1);
            flush = 1'b1;
            set_push(addi(5'd9, 12'h7AB), 32'h000DEAD0);
            step();
            flush = 1'b0;
            valid_from_if = 1'b0;
            chk("flush_valid", 32'(valid_2disp), 32'd0);
            chk("flush_full", 32'(is_full), 32'd0);
            disp_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step();
                if (valid_2disp) seen = 1'b1;
            end
            chk("flush_nothing_out", 32'(seen), 32'd0);
            set_push(addi(5'd4, 12'd44), 32'h3100);
            step();
            valid_from_if = 1'b0;
            step();
            chk("post_flush_valid", 32'(valid_2disp), 32'd1);
            chk("post_flush_pc", pc_2disp, 32'h3100);
            chk("post_flush_imm", imm_2disp, 32'd44);
        end

        // ---- rdy low freezes push, pop and flush ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_push(addi(5'd5, 12'(k)), 32'h4000 + 32'(k) * 4);
            step();
        end
        rdy = 1'b0;
        flush = 1'b1;
        disp_ready = 1'b1;
        set_push(addi(5'd6, 12'd99), 32'h4F00);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 32'(valid_2disp), 32'd1);
            chk("stall_pc", pc_2disp, 32'h4000);
        end
        rdy = 1'b1;
        flush = 1'b0;
        valid_from_if = 1'b0;
        step();
        chk("resume_pc1", pc_2disp, 32'h4004);
        chk("resume_valid1", 32'(valid_2disp), 32'd1);
        step();
        chk("resume_pc2", pc_2disp, 32'h4008);
        step();
        chk("resume_empty", 32'(valid_2disp), 32'd0);

        // ---- reset mid-stream ----
        begin
            logic seen = 1'b0;
            disp_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                set_push(addi(5'd7, 12'(k)), 32'h5000 + 32'(k) * 4);
                step();
            end
            valid_from_if = 1'b0;
            rst = 1'b0;
            step();
            chk("midrst_valid", 32'(valid_2disp), 32'd0);
            chk("midrst_pc", pc_2disp, 32'd0);
            rst = 1'b1;
            disp_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step();
                if (valid_2disp) seen = 1'b1;
            end
            chk("midrst_no_output", 32'(seen), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Circular instruction queue plus decode register between the instruction fetcher and the dispatch/reservation-station logic. Accepts fetched RV32I instructions with their PC and predicted next PC, buffers them, and presents one decoded instruction per cycle to dispatch through a valid/ready handshake. Provides the fetcher back-pressure (`is_full`) and a single-cycle flush for branch mispredict recovery.

## Interface
- `DEPTH_LOG`, 4: queue depth is 2^DEPTH_LOG entries (16).
- `FULL_MARGIN`, 2: `is_full` asserts when occupancy ≥ DEPTH − FULL_MARGIN.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-low.
- `rdy`  in  1  global ready; low freezes all state.
- `flush`  in  1  mispredict clear from commit logic.
- `valid_from_if`  in  1  fetcher push strobe.
- `instr_from_if`  in  32  raw instruction.
- `pc_from_if`  in  32  instruction PC.
- `pred_pc_from_if`  in  32  predicted next PC.
- `is_full`  out  1  back-pressure to fetcher.
- `disp_ready`  in  1  dispatch can accept this cycle.
- `valid_2disp`  out  1  output register holds a valid instruction.
- `op_2disp`  out  6  decoded operation (package enum).
- `rd_2disp`, `rs1_2disp`, `rs2_2disp`  out  5 each  register indices.
- `imm_2disp`  out  32  sign-extended immediate.
- `pc_2disp`, `pred_pc_2disp`  out  32 each  carried PC / predicted PC.

## Operation
- Storage: DEPTH entries of {instr, pc, pred_pc}; head/tail pointers DEPTH_LOG bits, wrap modulo DEPTH; occupancy counter DEPTH_LOG+1 bits.
- Push: `valid_from_if` high and occupancy < DEPTH → write at tail, tail+1. Push at occupancy == DEPTH is dropped (never legal; margin prevents it).
- Pop: queue non-empty and (output register empty or `valid_2disp && disp_ready`) → decode head entry into output register, head+1.
- Push and pop same cycle: occupancy unchanged; both pointers advance.
- Output register holds contents stable while `valid_2disp && !disp_ready`.
- Accept with queue empty: `valid_2disp` drops next cycle.
- Decode: full RV32I (LUI, AUIPC, JAL, JALR, 6 branches, 5 loads, 3 stores, 9 OP-IMM, 10 OP). Unused fields output 0 (rd for S/B; rs2 for I/U/J; rs1 for U/J). Immediates sign-extended per I/S/B/U/J format; B/J imm bit 0 = 0; U imm low 12 bits = 0. Unrecognised encoding → `OP_ILLEGAL`, other fields 0.
- Priority: reset > `rdy` low (hold everything, including flush) > flush > push/pop.
- Flush: next cycle head = tail = 0, occupancy 0, `valid_2disp` 0; concurrent push discarded.

## Timing
- Reset: all pointers/counter 0, `valid_2disp` 0, all data outputs 0, `is_full` 0.
- `is_full` combinational from registered occupancy; no dependence on same-cycle push.
- Latency: push at edge ending cycle t into empty queue → `valid_2disp` high in cycle t+2.
- Throughput: one pop per cycle sustained when `disp_ready` held high.
- `FULL_MARGIN` covers one in-flight fetch after `is_full` rises.
- Reset asserted mid-stream discards all entries; no output valid until a new push.

## Structure
- Shared package `rv32i_pkg`: op enum (6-bit, `OP_ILLEGAL` = 0), opcode/funct3/funct7 constants, `DATA_IDX_RANGE`/`ADDR_IDX` width macros.
- Sub-module `instr_decode`: purely combinational instruction → {op, rd, rs1, rs2, imm}; instantiated once on the queue head.
- Queue storage as register array; no RAM macro.

## Test plan
- Reset then push `0x00500093` (addi x1,x0,5) pc 0x0 → cycle t+2: `valid_2disp`=1, op=ADDI, rd=1, rs1=0, imm=5, pc=0x0.
- Push 14 entries with `disp_ready`=0 → `is_full` high at occupancy 14; 15th push accepted, output register holds first entry stable.
- Push `0xFE000EE3` (beq x0,x0,-4) → op=BEQ, rd=0, imm=0xFFFFFFFC.
- Continuous push + `disp_ready`=1 across 40 instructions → in-order output, one per cycle, pointers wrap twice, occupancy constant.
- Queue holding 5 entries, `flush` with simultaneous push → next cycle occupancy 0, `valid_2disp`=0, pushed instruction never appears.
- `rdy` low 3 cycles during push/pop/flush → state and outputs unchanged; resumes identically when `rdy` returns.
